// File: rtl/uart_tx_interface.sv
// rtl/uart_tx_interface.sv - memory-mapped 8N1 UART transmitter with store FIFO and status load
module uart_tx_interface #(
    parameter int CLKS_PER_BIT    = 434,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] write_data,
    input  logic [3:0]  byte_enable,
    input  logic        write_req,
    input  logic        read_req,
    output logic [31:0] read_data,
    output logic        read_data_valid,
    output logic        uart_tx
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = FIFO_DEPTH_LOG2;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] baud_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             tx_q;

    logic [7:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             overflow_q;
    logic             overflow_d;

    logic [31:0]      status;
    logic [31:0]      read_data_q;
    logic             read_valid_q;

    logic             push_req;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic             baud_done;
    logic             busy;
    logic             overflow_evt;
    logic             unused_bits;

    // Only byte lane 0 carries data; the rest of the store word is ignored.
    assign unused_bits  = ^{write_data[31:8], byte_enable[3:1]};

    assign push_req     = write_req & byte_enable[0];
    assign fifo_empty   = (count_q == '0);
    assign fifo_full    = (count_q == DEPTH_C);
    assign baud_done    = (baud_q == '0);
    assign pop          = !fifo_empty &&
                          ((state_q == S_IDLE) || (state_q == S_STOP && baud_done));
    assign push         = push_req && (!fifo_full || pop);
    assign overflow_evt = push_req && !push;
    assign busy         = !fifo_empty || (state_q != S_IDLE);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // A same-edge overflow wins over the clear-on-load.
    assign overflow_d = overflow_evt | (overflow_q & ~read_req);

    always_comb begin
        status                 = '0;
        status[0]              = busy;
        status[1]              = fifo_full;
        status[2]              = overflow_q;
        status[4 +: PTR_W + 1] = count_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= write_data[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            read_data_q  <= read_req ? status : 32'd0;
            read_valid_q <= read_req;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        shift_q <= fifo_mem[rd_ptr_q];
                        baud_q  <= BAUD_LAST;
                        tx_q    <= 1'b0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (baud_done) begin
                        baud_q    <= BAUD_LAST;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= S_DATA;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        baud_q <= BAUD_LAST;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_done) begin
                        // Chain straight into the next START when more data is queued.
                        if (pop) begin
                            shift_q <= fifo_mem[rd_ptr_q];
                            baud_q  <= BAUD_LAST;
                            tx_q    <= 1'b0;
                            state_q <= S_START;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign uart_tx         = tx_q;
    assign read_data       = read_data_q;
    assign read_data_valid = read_valid_q;

endmodule

// File: tb/tb_uart_tx_interface.sv
// tb/tb_uart_tx_interface.sv - directed self-checking bench for uart_tx_interface
module tb_uart_tx_interface;

    localparam int CB   = 4;
    localparam int CB16 = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] write_data;
    logic [3:0]  byte_enable;
    logic        write_req;
    logic        read_req;
    logic [31:0] rd4, rd16;
    logic        rdv4, rdv16, tx4, tx16;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  exp_bytes [8];
    int          starts[$];
    logic [31:0] rd_a, rd_b;
    logic [7:0]  rx_q[$];
    logic [7:0]  rx_byte;
    bit          rx_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx_interface #(.CLKS_PER_BIT(CB), .FIFO_DEPTH_LOG2(4)) dut4 (
        .clk(clk), .reset(reset), .write_data(write_data), .byte_enable(byte_enable),
        .write_req(write_req), .read_req(read_req), .read_data(rd4),
        .read_data_valid(rdv4), .uart_tx(tx4)
    );

    uart_tx_interface #(.CLKS_PER_BIT(CB16), .FIFO_DEPTH_LOG2(4)) dut16 (
        .clk(clk), .reset(reset), .write_data(write_data), .byte_enable(byte_enable),
        .write_req(write_req), .read_req(read_req), .read_data(rd16),
        .read_data_valid(rdv16), .uart_tx(tx16)
    );

    // Mid-bit sampling receiver on the CLKS_PER_BIT=16 instance.
    always begin
        @(negedge clk);
        if (rx_en && tx16 === 1'b0) begin
            repeat (CB16 / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CB16) @(negedge clk);
                rx_byte[i] = tx16;
            end
            repeat (CB16) @(negedge clk);
            checks++;
            if (tx16 !== 1'b1) begin
                failures++;
                $display("FAIL rx_stop_bit: got %b want 1", tx16);
            end
            rx_q.push_back(rx_byte);
        end
    end

    function automatic logic exp_tx(input int c, input int n);
        int p, f, s;
        if (c < 2) return 1'b1;
        p = c - 2;
        f = p / (10 * CB);
        if (f >= n) return 1'b1;
        s = (p % (10 * CB)) / CB;
        if (s == 0) return 1'b0;
        if (s == 9) return 1'b1;
        return exp_bytes[f][s-1];
    endfunction

    task automatic do_reset();
        reset       = 1'b1;
        write_req   = 1'b0;
        read_req    = 1'b0;
        write_data  = '0;
        byte_enable = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Stores n bytes from exp_bytes in cycles 0..n-1, loads in rd_cyc and rd_cyc+1,
    // and checks the serial line every cycle against the frame model.
    task automatic run_frames(input int n, input int ncyc, input int rd_cyc);
        bit bad_bus;
        int busy_until;
        bad_bus    = 1'b0;
        busy_until = -1;
        starts.delete();
        for (int c = 0; c < ncyc; c++) begin
            write_req   = (c < n);
            byte_enable = 4'b0001;
            if (c < n) write_data = {24'hDEADBE, exp_bytes[c]};
            else       write_data = 32'h0;
            read_req    = (c == rd_cyc) || (c == rd_cyc + 1);
            @(negedge clk);
            checks++;
            if (tx4 !== exp_tx(c, n)) begin
                failures++;
                $display("FAIL tx_line cycle %0d: got %b want %b", c, tx4, exp_tx(c, n));
            end
            if (c > busy_until && tx4 === 1'b0) begin
                starts.push_back(c);
                busy_until = c + 10 * CB - 1;
            end
            if (c == rd_cyc + 1)      rd_a = rdv4 ? rd4 : 32'hFFFF_FFFF;
            else if (c == rd_cyc + 2) rd_b = rdv4 ? rd4 : 32'hFFFF_FFFF;
            else if (rdv4 !== 1'b0 || rd4 !== 32'h0) bad_bus = 1'b1;
            @(posedge clk);
            #1;
        end
        write_req = 1'b0;
        read_req  = 1'b0;
        checks++;
        if (bad_bus) begin
            failures++;
            $display("FAIL idle_read_bus: got nonzero read_data/valid want 0");
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (tx4 !== 1'b1 || tx16 !== 1'b1) begin
            failures++;
            $display("FAIL reset_tx: got %b/%b want 1/1", tx4, tx16);
        end
        checks++;
        if (rd4 !== 32'h0 || rd16 !== 32'h0) begin
            failures++;
            $display("FAIL reset_read_data: got %h/%h want 0", rd4, rd16);
        end
        checks++;
        if (rdv4 !== 1'b0 || rdv16 !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid: got %b/%b want 0", rdv4, rdv16);
        end
    endtask

    task automatic test_single_byte();
        do_reset();
        exp_bytes[0] = 8'hA5;
        run_frames(1, 46, 41);
        checks++;
        if (starts.size() != 1 || starts[0] != 2) begin
            failures++;
            $display("FAIL single_start: got %0d starts want one at cycle 2", starts.size());
        end
        checks++;
        if (rd_a !== 32'h001) begin
            failures++;
            $display("FAIL single_busy_c41: got %h want 001", rd_a);
        end
        checks++;
        if (rd_b !== 32'h000) begin
            failures++;
            $display("FAIL single_idle_c42: got %h want 000", rd_b);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        exp_bytes[0] = 8'h55;
        exp_bytes[1] = 8'h0F;
        run_frames(2, 86, 81);
        checks++;
        if (starts.size() != 2 || starts[0] != 2 || starts[1] != 42) begin
            failures++;
            $display("FAIL b2b_starts: got %0d starts want cycles 2 and 42", starts.size());
        end
        checks++;
        if (rd_a !== 32'h001 || rd_b !== 32'h000) begin
            failures++;
            $display("FAIL b2b_status: got %h/%h want 001/000", rd_a, rd_b);
        end
    endtask

    task automatic test_lane_ignore();
        bit line_low;
        do_reset();
        line_low = 1'b0;
        for (int c = 0; c < 50; c++) begin
            write_req   = (c == 0);
            byte_enable = 4'b1110;
            write_data  = 32'h0000_00FF;
            read_req    = (c == 1);
            @(negedge clk);
            if (tx4 !== 1'b1) line_low = 1'b1;
            if (c == 2) begin
                checks++;
                if (rdv4 !== 1'b1 || rd4 !== 32'h000) begin
                    failures++;
                    $display("FAIL lane_status: got %h valid %b want 000 valid 1", rd4, rdv4);
                end
            end
            @(posedge clk);
            #1;
        end
        write_req = 1'b0;
        read_req  = 1'b0;
        checks++;
        if (line_low) begin
            failures++;
            $display("FAIL lane_tx_idle: got line low want high throughout");
        end
    endtask

    task automatic test_load_during_push();
        do_reset();
        write_req   = 1'b1;
        byte_enable = 4'b0001;
        write_data  = 32'h0000_003C;
        read_req    = 1'b1;
        @(posedge clk);
        #1;
        write_req = 1'b0;
        read_req  = 1'b1;
        @(negedge clk);
        checks++;
        if (rdv4 !== 1'b1 || rd4 !== 32'h000) begin
            failures++;
            $display("FAIL lp_first: got %h valid %b want 000 valid 1", rd4, rdv4);
        end
        @(posedge clk);
        #1;
        read_req = 1'b0;
        @(negedge clk);
        checks++;
        if (rdv4 !== 1'b1 || rd4 !== 32'h011) begin
            failures++;
            $display("FAIL lp_second: got %h valid %b want 011 valid 1", rd4, rdv4);
        end
        repeat (45) @(posedge clk);
        #1 read_req = 1'b1;
        @(posedge clk);
        #1 read_req = 1'b0;
        @(negedge clk);
        checks++;
        if (rd4 !== 32'h000) begin
            failures++;
            $display("FAIL lp_drained: got %h want 000", rd4);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        rx_q.delete();
        rx_en = 1'b1;
        for (int c = 0; c < 21; c++) begin
            write_req   = (c < 18);
            byte_enable = 4'b0001;
            write_data  = {24'h123456, 8'(8'h10 + c)};
            read_req    = (c == 18) || (c == 19);
            @(negedge clk);
            if (c == 19) begin
                checks++;
                if (rdv16 !== 1'b1 || rd16 !== 32'h107) begin
                    failures++;
                    $display("FAIL ovf_first_load: got %h want 107", rd16);
                end
            end
            if (c == 20) begin
                checks++;
                if (rdv16 !== 1'b1 || rd16 !== 32'h103) begin
                    failures++;
                    $display("FAIL ovf_second_load: got %h want 103", rd16);
                end
            end
            @(posedge clk);
            #1;
        end
        write_req = 1'b0;
        read_req  = 1'b0;
        repeat (2800) @(posedge clk);
        #1;
        rx_en = 1'b0;
        checks++;
        if (rx_q.size() != 17) begin
            failures++;
            $display("FAIL ovf_frame_count: got %0d want 17", rx_q.size());
        end
        for (int i = 0; i < 17 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== 8'(8'h10 + i)) begin
                failures++;
                $display("FAIL ovf_byte %0d: got %h want %h", i, rx_q[i], 8'(8'h10 + i));
            end
        end
        read_req = 1'b1;
        @(posedge clk);
        #1 read_req = 1'b0;
        @(negedge clk);
        checks++;
        if (rd16 !== 32'h000) begin
            failures++;
            $display("FAIL ovf_drained: got %h want 000", rd16);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_frame();
        bit line_low;
        do_reset();
        exp_bytes[0] = 8'hF0;
        exp_bytes[1] = 8'h11;
        exp_bytes[2] = 8'h22;
        exp_bytes[3] = 8'h33;
        exp_bytes[4] = 8'h44;
        for (int c = 0; c < 19; c++) begin
            write_req   = (c < 5);
            byte_enable = 4'b0001;
            write_data  = (c < 5) ? {24'h0, exp_bytes[c]} : 32'h0;
            @(posedge clk);
            #1;
        end
        write_req = 1'b0;
        #1;
        checks++;
        if (tx4 !== 1'b0) begin
            failures++;
            $display("FAIL rmf_bit3: got %b want 0", tx4);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (tx4 !== 1'b1) begin
            failures++;
            $display("FAIL rmf_async_tx: got %b want 1", tx4);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        read_req = 1'b1;
        @(posedge clk);
        #1 read_req = 1'b0;
        @(negedge clk);
        checks++;
        if (rdv4 !== 1'b1 || rd4 !== 32'h000) begin
            failures++;
            $display("FAIL rmf_status: got %h valid %b want 000 valid 1", rd4, rdv4);
        end
        line_low = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (tx4 !== 1'b1) line_low = 1'b1;
        end
        checks++;
        if (line_low) begin
            failures++;
            $display("FAIL rmf_no_frames: got line activity want idle");
        end
        @(posedge clk);
        #1;
        exp_bytes[0] = 8'h96;
        run_frames(1, 44, -5);
        checks++;
        if (starts.size() != 1 || starts[0] != 2) begin
            failures++;
            $display("FAIL rmf_new_start: got %0d starts want one at cycle 2", starts.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_lane_ignore();
        test_load_during_push();
        test_overflow();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_interface.md
# uart_tx_interface

Memory-mapped UART transmitter peripheral sitting directly downstream of `mem_mapper`, alongside `led_interface`, on the same single-register peripheral bus. CPU stores push bytes into a 16-entry FIFO. A serializer drains the FIFO onto `uart_tx` as 8N1 frames (LSB first). CPU loads return a status word, so firmware can poll for space and completion.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200); legal range ≥ 2.
- `FIFO_DEPTH_LOG2`, default 4: FIFO depth is 2^FIFO_DEPTH_LOG2 (16).

Ports:
- `clk`  input  1  the single clock; all logic is on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `write_data`  input  32  store data; only bits [7:0] are used.
- `byte_enable`  input  4  store byte lanes; only bit 0 is meaningful.
- `write_req`  input  1  store strobe, one cycle per access.
- `read_req`  input  1  load strobe, one cycle per access.
- `read_data`  output  32  status word; qualified by `read_data_valid`.
- `read_data_valid`  output  1  one-cycle pulse answering `read_req`.
- `uart_tx`  output  1  serial line; idles high.

## Operation

- **Store push**
  - Push condition: `write_req`=1 and `byte_enable[0]`=1. The block then pushes `write_data[7:0]`.
  - If `byte_enable[0]`=0, the store is ignored and has no side effects.
- **Push acceptance**
  - A push is accepted if count < depth, or if a pop occurs on the same edge. In that case the count is unchanged.
  - Otherwise the byte is dropped and the sticky `overflow` bit is set.
- **Status word** (returned on load):
  - [0] `busy`: FIFO non-empty or state ≠ IDLE.
  - [1] `full`: count = depth.
  - [2] `overflow`.
  - [3] 0.
  - [8:4] `count`, 0..16.
  - [31:9] 0.
- **Load side effect**
  - A load clears `overflow` on the same edge the status is captured; the returned value is the pre-clear value.
  - If an overflow event occurs on the same edge as the load, `overflow` remains 1.
- **Simultaneous access**
  - Simultaneous `read_req` and `write_req` are both serviced.
  - The status reflects the state before that edge's push or pop.
- **Serializer FSM:** IDLE → START → DATA → STOP.
  - IDLE: `uart_tx`=1. When the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `uart_tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `uart_tx`=shift[0] for `CLKS_PER_BIT` cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: `uart_tx`=1 for `CLKS_PER_BIT` cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- **Baud counter**
  - Loads `CLKS_PER_BIT-1` on every state entry or bit entry.
  - Decrements to 0; the bit ends on the edge where the counter is 0.
  - Width is ceil(log2(`CLKS_PER_BIT`)).
- **FIFO structure**
  - Circular buffer with read/write pointers of `FIFO_DEPTH_LOG2` bits; pointers wrap modulo depth.
  - Separate count register of `FIFO_DEPTH_LOG2+1` bits.

## Timing

- **Reset values**
  - `uart_tx`=1, `read_data`=0, `read_data_valid`=0.
  - FIFO empty, pointers 0, `overflow`=0, state IDLE.
  - Reset asserted mid-frame aborts immediately; `uart_tx` goes high asynchronously and FIFO contents are discarded.
- **Load latency**
  - `read_req` in cycle N → `read_data_valid`=1 with the status in cycle N+1.
  - Otherwise `read_data_valid`=0 and `read_data` holds 0.
- **Store-to-line latency**
  - Store in cycle N into an empty FIFO with IDLE state → push on edge N, pop on edge N+1.
  - `uart_tx` falls in cycle N+2.
- **Frame length:** exactly 10×`CLKS_PER_BIT` cycles. Back-to-back frames have no gap between the STOP bit and the next START bit.
- **Pipelining:** stores and loads are accepted every cycle; there is no backpressure.

## Test plan

- **Single byte:** `CLKS_PER_BIT`=4; store 0x000000A5 with `byte_enable`=4'b0001 in cycle 0.
  - Expect `uart_tx` low in cycles 2–5, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high from cycle 38.
  - `busy` reads 0 from cycle 42.
- **Back-to-back frames:** store 0x55 then 0x0F in consecutive cycles.
  - Expect the second START to begin exactly 40 cycles after the first, with no idle high gap beyond the STOP bit.
- **Overflow:** `CLKS_PER_BIT`=16; store 18 bytes in cycles 0–17, then load.
  - Expect status `count`=16, `full`=1, `overflow`=1, `busy`=1 (0x107).
  - A second load returns `overflow`=0 (0x103).
  - Exactly 17 frames are emitted; the 18th byte never appears.
- **Lane ignore:** store 0xFF with `byte_enable`=4'b1110.
  - Expect `uart_tx` stays high, `count` stays 0, `overflow` stays 0.
- **Load during push:** simultaneous load and store on an empty FIFO.
  - Expect status 0x000 returned next cycle.
  - A following load returns `busy`=1.
- **Reset mid-frame:** assert `reset` during DATA bit 3 with 5 bytes queued.
  - Expect `uart_tx`=1 immediately and status 0x000 after release.
  - No further frames; a new store transmits normally.
